// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared RV32M definitions used by the decoder/ALU controller and the
// iterative multiply/divide sequencer.
//   FUNCT7_MULDIV  : Funct7 value that steers an R-type instruction to the
//                    multiply/divide unit instead of the ALU.
//   muldiv_op_e    : operation encoding, equal to the instruction's Funct3.
//   muldiv_state_e : sequencer FSM states.
//   op_is_div / op_signed_a / op_signed_b : operation class helpers.
package riscv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    // Divide and remainder ops all have Funct3[2] set.
    function automatic logic op_is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
    function automatic logic op_signed_a(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM (MULHSU leaves it unsigned).
    function automatic logic op_signed_b(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_core_step.sv
// muldiv_core_step
// Combinational single-iteration datapath for the multiply/divide sequencer.
// Works purely on magnitudes; all sign handling lives in the sequencer.
// Ports:
//   mode_div : 1 = restoring-division step, 0 = shift-add multiply step
//   acc_in   : 2*XLEN accumulator. Multiply: {partial product hi, multiplier
//              bits still to consume}. Divide: {partial remainder, dividend
//              bits still to consume / quotient bits produced so far}.
//   operand  : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_out  : accumulator after this iteration (bit 0 is 0 in divide mode)
//   q_bit    : new quotient bit (divide) or new accumulator bit 0 (multiply)
import riscv_pkg::*;

module muldiv_core_step #(
    parameter int XLEN = 32
) (
    input  logic                mode_div,
    input  logic [2*XLEN-1:0]   acc_in,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_out,
    output logic                q_bit
);

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_acc;
    logic [XLEN:0]     div_shifted;
    logic [XLEN:0]     div_trial;
    logic              div_fits;
    logic [2*XLEN-1:0] div_acc;

    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit (acc_in[0]) is set, then shift the whole accumulator
    // right one place, keeping the carry out of the add.
    always_comb begin
        mul_sum = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
        mul_acc = {mul_sum, acc_in[XLEN-1:1]};
    end

    // Divide: shift the next dividend bit into the partial remainder and try
    // to subtract the divisor. The remainder is always below the divisor, so
    // the XLEN+1 bit trial difference is negative exactly when its top bit is
    // set, in which case the shifted remainder is restored.
    always_comb begin
        div_shifted = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]};
        div_trial   = div_shifted - {1'b0, operand};
        div_fits    = ~div_trial[XLEN];
        div_acc     = {(div_fits ? div_trial[XLEN-1:0] : div_shifted[XLEN-1:0]),
                       acc_in[XLEN-2:0], 1'b0};
    end

    always_comb begin
        acc_out = mode_div ? div_acc : mul_acc;
        q_bit   = mode_div ? div_fits : mul_acc[0];
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative RV32M multiply/divide unit sitting beside the ALU in EX.
// Accepts one request in IDLE, iterates XLEN cycles in CALC, applies sign
// correction and RISC-V corner cases in FIX and presents the registered
// result with a one-cycle done pulse in DONE. The pipeline is held through
// stall until DONE, where the EX instruction advances and writeback selects
// result.
// Optional build macro MULDIV_EARLY_OUT_EN: a request with a zero operand
// (or MUL with both operands 0/1) skips CALC and completes in 2 cycles.
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start          : request valid (Funct7 = FUNCT7_MULDIV, R-type, EX valid)
//   funct3         : operation select (muldiv_op_e)
//   op_a, op_b     : rs1 / rs2 values
//   flush          : abort any in-flight operation, blocks a same-cycle start
//   stall          : freeze PC/IF/ID/EX registers
//   busy           : FSM not in IDLE
//   done           : one-cycle completion pulse, result valid
//   result         : registered result, held until the next completion
import riscv_pkg::*;

module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_CALC = 2'(CALC);
    localparam logic [1:0] S_FIX  = 2'(FIX);
    localparam logic [1:0] S_DONE = 2'(DONE);

    logic [1:0]         state_q, state_d;
    muldiv_op_e         op_q;
    logic [XLEN-1:0]    mag_a_q, mag_b_q;
    logic               sign_a_q, sign_b_q;
    logic [2*XLEN-1:0]  acc_q;
    logic [CW-1:0]      cnt_q;
    logic [XLEN-1:0]    result_q;

    muldiv_op_e         in_op;
    logic               in_div;
    logic               in_sign_a, in_sign_b;
    logic [XLEN-1:0]    in_mag_a, in_mag_b;
    logic               start_ok;
    logic               early_out;
    logic [2*XLEN-1:0]  acc_init;

    logic               cur_div;
    logic [2*XLEN-1:0]  step_acc;
    logic               step_bit;

    logic [2*XLEN-1:0]  prod;
    logic [XLEN-1:0]    quot_s, rem_s, orig_a;
    logic               div_zero;
    logic [XLEN-1:0]    fix_val;

    // Request decode: magnitudes and signs of the incoming operands.
    always_comb begin
        in_op     = muldiv_op_e'(funct3);
        in_div    = op_is_div(in_op);
        in_sign_a = op_signed_a(in_op) && op_a[XLEN-1];
        in_sign_b = op_signed_b(in_op) && op_b[XLEN-1];
        in_mag_a  = in_sign_a ? -op_a : op_a;
        in_mag_b  = in_sign_b ? -op_b : op_b;
        start_ok  = (state_q == S_IDLE) && start && !flush;
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Trivial operands: the product/quotient/remainder are known without
    // iterating, so the accumulator is preloaded with the final value.
    assign early_out = (op_a == '0) || (op_b == '0) ||
                       ((in_op == OP_MUL) && (op_a[XLEN-1:1] == '0) && (op_b[XLEN-1:1] == '0));
`else
    assign early_out = 1'b0;
`endif

    // Multiply starts with the multiplier in the low half; divide starts
    // with the dividend in the low half. Both start with a zero upper half.
    always_comb begin
        acc_init = in_div ? {{XLEN{1'b0}}, in_mag_a} : {{XLEN{1'b0}}, in_mag_b};
`ifdef MULDIV_EARLY_OUT_EN
        // Every early-out case has a magnitude product of 0 or 1 and a
        // quotient/remainder of 0 (divide by zero is overridden in FIX).
        if (early_out) begin
            acc_init = {{(2*XLEN-1){1'b0}}, (in_mag_a[0] & in_mag_b[0] & ~in_div)};
        end
`endif
    end

    // Next-state logic; flush overrides everything and returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = early_out ? S_FIX : S_CALC;
                S_CALC:  if (cnt_q == '0) state_d = S_FIX;
                S_FIX:   state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign cur_div = op_is_div(op_q);

    muldiv_core_step #(
        .XLEN (XLEN)
    ) u_step (
        .mode_div (cur_div),
        .acc_in   (acc_q),
        .operand  (cur_div ? mag_b_q : mag_a_q),
        .acc_out  (step_acc),
        .q_bit    (step_bit)
    );

    // Operand capture in IDLE, one iteration per CALC cycle. Operands are
    // only captured when a request is actually accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_MUL;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start_ok) begin
            op_q     <= in_op;
            mag_a_q  <= in_mag_a;
            mag_b_q  <= in_mag_b;
            sign_a_q <= in_sign_a;
            sign_b_q <= in_sign_b;
            acc_q    <= acc_init;
            cnt_q    <= CW'(XLEN - 1);
        end else if (state_q == S_CALC) begin
            acc_q    <= cur_div ? {step_acc[2*XLEN-1:1], step_bit} : step_acc;
            cnt_q    <= cnt_q - 1'b1;
        end
    end

    // Sign correction and result selection. Signed overflow
    // (0x80000000 / -1) needs no special case: the magnitude quotient is
    // 0x80000000 with remainder 0, and negating 0x80000000 leaves it
    // unchanged, which is exactly the RISC-V defined result.
    always_comb begin
        prod     = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quot_s   = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_s    = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        orig_a   = sign_a_q ? -mag_a_q : mag_a_q;
        div_zero = (mag_b_q == '0);
        fix_val  = '0;
        case (op_q)
            OP_MUL:                       fix_val = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_val = div_zero ? '1 : quot_s;
            OP_REM, OP_REMU:              fix_val = div_zero ? orig_a : rem_s;
            default:                      fix_val = '0;
        endcase
    end

    // The result register only changes when FIX completes unflushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else if ((state_q == S_FIX) && !flush) begin
            result_q <= fix_val;
        end
    end

    assign result = result_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE) && !flush;
    assign stall  = start_ok || (state_q == S_CALC) || (state_q == S_FIX);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
// Directed bench for muldiv_sequencer. Each issued request pushes its
// expected result, latency and stall count into a scoreboard queue; a
// monitor on the falling edge pops and compares whenever done is high.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          start_cyc;
        int          stall_base;
        string       name;
    } exp_t;

    exp_t sbq[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int stall_total = 0;
    logic [31:0] last_res = 32'h0;

    muldiv_sequencer #(
        .XLEN (32)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: after a rising edge, cyc names the cycle that edge began.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Latency from acceptance (cycle 0) to done.
    function automatic int expLat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (a == 32'h0 || b == 32'h0 || (f3 == 3'b000 && a <= 32'h1 && b <= 32'h1)) return 2;
`endif
        return 34;
    endfunction

    // Monitor: counts stall cycles and checks every done pulse against the
    // scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall) stall_total <= stall_total + 1;
            if (done) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_done", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    checkOutput({e.name, "_result"}, result, e.res);
                    checkOutput({e.name, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
                    checkOutput({e.name, "_stall_cycles"}, 32'(stall_total - e.stall_base), 32'(e.lat));
                    checkOutput({e.name, "_stall_at_done"}, {31'h0, stall}, 32'h0);
                end
            end
        end
    end

    task automatic pushExpected(input string name, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        sbq.push_back('{exp, expLat(f3, a, b), cyc, stall_total, name});
        last_res = exp;
    endtask

    // Wait (bounded) until the scoreboard drains; returns in the cycle after DONE.
    task automatic waitDone();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0) begin
            checkOutput("done_timeout", 32'h0, 32'h1);
            sbq.delete();
        end
    endtask

    // Called at posedge+1 with the DUT idle: one-cycle start, then wait.
    task automatic applyStimulus(input string name, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        pushExpected(name, f3, a, b, exp);
        @(posedge clk); #1;
        start = 1'b0;
        waitDone();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        op_a   = 32'h0;
        op_b   = 32'h0;

        #2;
        checkOutput("reset_done",   {31'h0, done},  32'h0);
        checkOutput("reset_busy",   {31'h0, busy},  32'h0);
        checkOutput("reset_stall",  {31'h0, stall}, 32'h0);
        checkOutput("reset_result", result,         32'h0);

        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Multiply family.
        applyStimulus("mul_7x-3",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        applyStimulus("mul_small",     3'b000, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500);
        applyStimulus("mul_1x1",       3'b000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001);
        applyStimulus("mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        applyStimulus("mulh_neg_pos",  3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF);
        applyStimulus("mulhu_max_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        applyStimulus("mulhsu_m1_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Divide family.
        applyStimulus("div_-7_2",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
        applyStimulus("rem_-7_2",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
        applyStimulus("divu_100_7",    3'b101, 32'd100,       32'd7,         32'd14);
        applyStimulus("remu_100_7",    3'b111, 32'd100,       32'd7,         32'd2);
        applyStimulus("divu_0_5",      3'b101, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000);

        // Corner cases.
        applyStimulus("div_5_0",       3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
        applyStimulus("rem_5_0",       3'b110, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005);
        applyStimulus("div_-6_0",      3'b100, 32'hFFFF_FFFA, 32'h0000_0000, 32'hFFFF_FFFF);
        applyStimulus("div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        applyStimulus("rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        applyStimulus("remu_x_0",      3'b111, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9);

        // Flush in the same cycle as start: nothing is accepted.
        start  = 1'b1; flush = 1'b1;
        funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        checkOutput("flush_with_start_busy", {31'h0, busy}, 32'h0);

        // Flush in the middle of CALC: no done, result unchanged.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        checkOutput("flush_pre_busy", {31'h0, busy}, 32'h1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush_busy",   {31'h0, busy}, 32'h0);
        checkOutput("flush_result", result,        last_res);
        repeat (40) begin @(posedge clk); #1; end
        checkOutput("flush_result_held", result, last_res);
        applyStimulus("after_flush_divu", 3'b101, 32'd1000, 32'd9, 32'd111);

        // start held through DONE: second request accepted in the IDLE cycle.
        start  = 1'b1;
        funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5;
        pushExpected("b2b_first", 3'b000, 32'd3, 32'd5, 32'd15);
        waitDone();
        pushExpected("b2b_second", 3'b000, 32'd3, 32'd5, 32'd15);
        @(posedge clk); #1;
        start = 1'b0;
        waitDone();

        // Asynchronous reset in the middle of CALC.
        start  = 1'b1;
        funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy",   {31'h0, busy},  32'h0);
        checkOutput("rst_mid_done",   {31'h0, done},  32'h0);
        checkOutput("rst_mid_stall",  {31'h0, stall}, 32'h0);
        checkOutput("rst_mid_result", result,         32'h0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus("after_reset_rem", 3'b110, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its own control FSM, sitting beside the main ALU in the EX stage.
- The decoder routes Funct7 = 0000001 R-type instructions here instead of to the ALU; Funct3 selects the operation.
- Holds the pipeline via `stall` while iterating, then presents one registered result.
- Shares the EX operand buses with the ALU; the writeback mux selects `result` when `done` is high.

Parameters:
- XLEN, 32, operand/result width; iteration count = XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request valid (Funct7 = 0000001, R-type, EX stage valid).
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value.
- op_b  in  XLEN  rs2 value.
- flush  in  1  abort in-flight operation (branch/exception kill).
- stall  out  1  freeze PC/IF/ID/EX registers.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse; `result` valid.
- result  out  XLEN  registered result, held until next completion.

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - `rst_n` is asynchronous and active-low.
  - Reset values: state = IDLE, `done` = 0, `busy` = 0, `result` = 0, counter = 0, all internal registers = 0.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - On `start` && !`flush`: latch funct3, take |op_a| and |op_b| per signedness, record signs, go to CALC.
  - Signedness: MULH signs both operands; MULHSU signs op_a only; DIV/REM sign both; MUL/MULHU/DIVU/REMU sign neither.
- CALC: one iteration per cycle for XLEN cycles; counter runs XLEN-1 down to 0, then go to FIX.
  - Multiply: shift-add on magnitudes into a 2*XLEN accumulator.
  - Divide: restoring division on magnitudes, one quotient bit per cycle.
- FIX: one cycle of sign correction and selection, then go to DONE.
  - Multiply: negate the 2*XLEN product if the operand signs differ. MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits.
  - Divide: quotient is negative if the signs differ (signed ops only); remainder takes the dividend's sign.
- DONE: `done` = 1 for exactly this cycle, `result` registered; return to IDLE the next cycle.
- `stall` (combinational) = (IDLE && `start` && !`flush`) || CALC || FIX. `stall` = 0 in DONE, so the EX instruction advances while `done` is high.
- Latency: start accepted at cycle 0; `done` at cycle XLEN+2 (34 for XLEN = 32).
- `busy` = state != IDLE.
- RISC-V corner cases, resolved in FIX with the same latency:
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = op_a.
  - Signed overflow (op_a = 0x80000000, op_b = -1): DIV = 0x80000000, REM = 0.
- `flush` in any state: next state is IDLE, no `done`, `result` unchanged. A `flush` in the same cycle as `start` wins and no operation is accepted.
- `start` while `busy` is ignored; operands are captured only in IDLE.
- Back-to-back requests: a new `start` is accepted in the cycle after DONE (IDLE), never in DONE itself.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: when entering from IDLE, if op_b = 0 or op_a = 0 (or both operands are 0/1 for MUL), skip CALC and go directly to FIX.
  - Latency from start to `done` = 2 cycles.
  - Results are identical to the full path.
- Undefined: every operation takes the full XLEN+2 cycles; no early-out comparators are synthesized.

Decomposition:
- Shared package riscv_pkg:
  - muldiv_op_e enum, encoding the Funct3 values above.
  - Constant FUNCT7_MULDIV = 7'b0000001.
  - muldiv_state_e enum {IDLE, CALC, FIX, DONE}.
- The decoder/ALUController uses FUNCT7_MULDIV to steer requests here.
- One natural sub-module: muldiv_core_step, a combinational single-iteration datapath. It takes the mode (mul/div) plus the accumulator, multiplicand/divisor and counter bit, and returns the next accumulator and quotient bit. The FSM, sign handling and corner cases stay in muldiv_sequencer.

Test Plan:
- MUL 7 × -3 (funct3 000) -> `done` at cycle 34, `result` = 0xFFFFFFEB; `stall` high cycles 0–33, low at 34.
- MULH 0x80000000 × 0x80000000 -> `result` = 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000; REM of the same -> 0. All with `done` at cycle 34, or cycle 2 with MULDIV_EARLY_OUT_EN for the /0 cases.
- `flush` at CALC cycle 10 -> `busy` = 0 next cycle, no `done` pulse, `result` keeps its previous value; a new `start` is then accepted and completes normally.
- `rst_n` low during CALC -> all outputs 0 asynchronously. `start` held high through DONE -> a second operation starts in the cycle after DONE; `done` pulses twice, 35 cycles apart.
